// File: rtl/wb_addr_decoder_n_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_addr_decoder_n_if
// Purpose  : Wishbone bus bundle between one bus master, the address
//            decoder and NUM_SLAVES peripheral slaves.
// Revision : 1.0  initial release
// ============================================================================
interface wb_addr_decoder_n_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SLOT_BITS  = 8
);

  // Master side (bridge <-> decoder)
  logic [ADDR_W-1:0]            m_adr_i;
  logic [DATA_W-1:0]            m_dat_i;
  logic [DATA_W-1:0]            m_dat_o;
  logic                         m_we_i;
  logic                         m_cyc_i;
  logic                         m_stb_i;
  logic                         m_ack_o;
  logic                         m_err_o;

  // Slave side (decoder <-> peripherals)
  logic [SLOT_BITS-1:0]         s_adr_o;
  logic [DATA_W-1:0]            s_dat_o;
  logic                         s_we_o;
  logic [NUM_SLAVES-1:0]        s_cyc_o;
  logic [NUM_SLAVES-1:0]        s_stb_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  // The bus master (SPI bridge) view
  modport master (
    output m_adr_i, m_dat_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o
  );

  // The peripheral slaves view
  modport slave (
    input  s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i
  );

  // The decoder view: slave towards the bridge, master towards peripherals
  modport dec (
    input  m_adr_i, m_dat_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/wb_addr_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : wb_addr_decoder_n
// Purpose  : Registered Wishbone address decoder for one master and up to
//            NUM_SLAVES slaves. Decodes the slot from the upper address
//            bits, strobes exactly one slave, muxes its read data back,
//            answers unmapped slots with an error and keeps a saturating
//            count of error responses.
// Options  : WB_DEC_TIMEOUT_EN - when defined, a watchdog ends an ACTIVE
//            access with an error after TIMEOUT+1 strobe cycles without ack.
// Revision : 1.0  initial release
// ============================================================================
module wb_addr_decoder_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SLOT_BITS  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_addr_decoder_n_if.dec    bus,
  output logic [7:0]          err_cnt_o
);

  localparam int SLOT_W = ADDR_W - SLOT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Elaboration marker: a hierarchy containing this block means the
  // parameter set is outside the supported range.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_param_range_bad
  end

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                 state_q,   state_d;
  logic [SLOT_BITS-1:0]   adr_q,     adr_d;
  logic [DATA_W-1:0]      wdat_q,    wdat_d;
  logic                   we_q,      we_d;
  logic [NUM_SLAVES-1:0]  sel_q,     sel_d;
  logic [DATA_W-1:0]      rdat_q,    rdat_d;
  logic                   ack_q,     ack_d;
  logic                   err_q,     err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0]      req_slot;
  logic                   req_mapped;
  logic [NUM_SLAVES-1:0]  req_onehot;
  logic                   req_valid;

  assign req_slot   = bus.m_adr_i[ADDR_W-1:SLOT_BITS];
  assign req_mapped = ({1'b0, req_slot} < (SLOT_W+1)'(NUM_SLAVES));
  assign req_valid  = bus.m_cyc_i & bus.m_stb_i;

  // One-hot select vector for the requested slot (zero when unmapped).
  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_slot == SLOT_W'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Selected-slave response path: only the strobed slave is listened to.
  // --------------------------------------------------------------------------
  logic                   sel_ack;
  logic [DATA_W-1:0]      sel_rdata;

  assign sel_ack = |(bus.s_ack_i & sel_q);

  // Read-data mux driven by the latched one-hot select.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) begin
        sel_rdata = sel_rdata | bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  logic timeout_hit;

`ifdef WB_DEC_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  // Count cycles spent in ACTIVE; the count is zero on entry to ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_ACTIVE) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  // Fires on the (TIMEOUT+1)-th edge after the strobe was raised.
  assign timeout_hit = (state_q == ST_ACTIVE) && (to_cnt_q == 16'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Error counter increment, saturating at 255
  // --------------------------------------------------------------------------
  logic [7:0] err_cnt_inc;
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  // Next-state and next-output logic for the decoder FSM.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          adr_d  = bus.m_adr_i[SLOT_BITS-1:0];
          wdat_d = bus.m_dat_i;
          we_d   = bus.m_we_i;
          if (req_mapped) begin
            sel_d   = req_onehot;
            state_d = ST_ACTIVE;
          end else begin
            rdat_d    = '1;
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc;
            state_d   = ST_RESP;
          end
        end
      end

      ST_ACTIVE: begin
        // A master abort outranks everything; ack outranks the watchdog.
        if (!bus.m_cyc_i) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          sel_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
          if (!we_q) begin
            rdat_d = sel_rdata;
          end
        end else if (timeout_hit) begin
          sel_d     = '0;
          rdat_d    = '1;
          err_d     = 1'b1;
          err_cnt_d = err_cnt_inc;
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        // Response cycle: the request inputs are deliberately ignored here.
        state_d = ST_IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.m_dat_o = rdat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.m_err_o = err_q;
  assign bus.s_adr_o = adr_q;
  assign bus.s_dat_o = wdat_q;
  assign bus.s_we_o  = we_q;
  assign bus.s_cyc_o = sel_q;
  assign bus.s_stb_o = sel_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_addr_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_addr_decoder_n
// Purpose  : Self-checking bench for wb_addr_decoder_n. Transactions are
//            described by when the slave acks / the master aborts; the
//            expected bus timeline is derived from those numbers.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_addr_decoder_n;

  localparam int NSL = 4;
  localparam int TMO = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b1;

  // Expected DUT outputs for the current cycle
  logic [NSL-1:0] exp_cyc  = '0;
  logic           exp_ack  = 1'b0;
  logic           exp_err  = 1'b0;
  logic [7:0]     exp_dat  = '0;
  logic [7:0]     exp_cnt  = '0;
  logic [7:0]     exp_adr  = '0;
  logic [7:0]     exp_sdat = '0;
  logic           exp_we   = 1'b0;

  logic [7:0]     sd [NSL];   // slave read data currently driven

  wb_addr_decoder_n_if #(.NUM_SLAVES(NSL), .ADDR_W(16), .DATA_W(8), .SLOT_BITS(8)) bus ();

  wb_addr_decoder_n #(
    .NUM_SLAVES(NSL), .ADDR_W(16), .DATA_W(8), .SLOT_BITS(8), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Cycle-by-cycle comparison against the expected timeline.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("s_cyc_o",   32'(bus.s_cyc_o), 32'(exp_cyc));
      chk("s_stb_o",   32'(bus.s_stb_o), 32'(exp_cyc));
      chk("m_ack_o",   32'(bus.m_ack_o), 32'(exp_ack));
      chk("m_err_o",   32'(bus.m_err_o), 32'(exp_err));
      chk("m_dat_o",   32'(bus.m_dat_o), 32'(exp_dat));
      chk("err_cnt_o", 32'(err_cnt),     32'(exp_cnt));
      chk("s_adr_o",   32'(bus.s_adr_o), 32'(exp_adr));
      chk("s_dat_o",   32'(bus.s_dat_o), 32'(exp_sdat));
      chk("s_we_o",    32'(bus.s_we_o),  32'(exp_we));
    end
  end

  // Drive fresh slave data and random acks on non-selected slaves.
  task automatic drive_slaves(input int sel, input bit ack, input int force_val);
    logic [NSL-1:0] noise;
    for (int k = 0; k < NSL; k++) begin
      sd[k] = 8'($urandom);
      if (k == sel && force_val >= 0) sd[k] = 8'(force_val);
      bus.s_dat_i[k*8 +: 8] = sd[k];
    end
    noise = NSL'($urandom);
    if (sel >= 0) noise[sel] = ack;
    bus.s_ack_i = noise;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive_slaves(-1, 1'b0, -1);
  endtask

  // ack_at : edge (counted from the request edge 0) at which the selected
  //          slave's ack is sampled, 0 = never acks.
  // drop_at: edge at which m_cyc_i is first seen low, 0 = never.
  task automatic run_txn(input logic [15:0] adr, input logic [7:0] wdat, input bit we,
                         input int ack_at, input int drop_at, input int rdval);
    int slot, sel, end_e, kind, e;
    bit mapped, done;
    logic [NSL-1:0] oh;
    logic [7:0] pre_dat;
    slot   = int'(adr[15:8]);
    mapped = (slot < NSL);
    sel    = mapped ? slot : -1;
    oh     = mapped ? (NSL'(1) << slot) : '0;
    end_e  = 1000000;
    kind   = 0;   // 1 ack, 2 timeout, 3 abort
    if (ack_at > 0) begin end_e = ack_at; kind = 1; end
`ifdef WB_DEC_TIMEOUT_EN
    if (TMO + 1 < end_e) begin end_e = TMO + 1; kind = 2; end
`endif
    if (drop_at > 0 && drop_at < end_e) begin end_e = drop_at; kind = 3; end
    if (mapped && kind == 0) begin
      total++; bad++;
      $display("FAIL plan: txn %h has no end, got none required ack or drop", adr);
      return;
    end
    bus.m_adr_i = adr;
    bus.m_dat_i = wdat;
    bus.m_we_i  = we;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    drive_slaves(sel, 1'b0, rdval);
    done = 1'b0;
    e = 0;
    while (!done) begin
      pre_dat = mapped ? sd[slot] : 8'h00;
      @(posedge clk); #1;
      if (e == 0) begin exp_adr = adr[7:0]; exp_sdat = wdat; exp_we = we; end
      if (!mapped) begin
        if (e == 0) begin
          exp_err = 1'b1; exp_dat = 8'hFF; exp_cnt = sat_inc(exp_cnt);
          bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
        end else begin
          exp_err = 1'b0; done = 1'b1;
        end
      end else if (e < end_e) begin
        exp_cyc = oh;
        if (kind == 3 && e + 1 == drop_at) begin bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; end
      end else if (e == end_e) begin
        exp_cyc = '0;
        if (kind == 1) begin
          exp_ack = 1'b1;
          if (!we) exp_dat = pre_dat;
        end else if (kind == 2) begin
          exp_err = 1'b1; exp_dat = 8'hFF; exp_cnt = sat_inc(exp_cnt);
        end
        bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
        if (kind == 3) done = 1'b1;
      end else begin
        exp_ack = 1'b0; exp_err = 1'b0; done = 1'b1;
      end
      drive_slaves(sel, mapped && kind == 1 && e + 1 == ack_at, rdval);
      e++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "time limit");
  end

  initial begin
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_we_i = 1'b0;
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    drive_slaves(-1, 1'b0, -1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();

    // Write 0x5A to 0x0001, slave 0 acks one cycle after strobe
    run_txn(16'h0001, 8'h5A, 1'b1, 2, 0, -1);
    chk("lit wr s_adr", 32'(bus.s_adr_o), 32'h01);
    chk("lit wr s_dat", 32'(bus.s_dat_o), 32'h5A);
    chk("lit wr s_we",  32'(bus.s_we_o),  32'h1);
    chk("lit wr cnt",   32'(err_cnt),     32'h0);

    // Read 0x0203, slave 2 returns 0xC3 after 3 cycles
    run_txn(16'h0203, 8'h00, 1'b0, 3, 0, 8'hC3);
    chk("lit rd m_dat", 32'(bus.m_dat_o), 32'hC3);

    // Unmapped read 0x0700
    run_txn(16'h0700, 8'h00, 1'b0, 0, 0, -1);
    chk("lit unmapped m_dat", 32'(bus.m_dat_o), 32'hFF);
    chk("lit unmapped cnt",   32'(err_cnt),     32'h1);

    // Slave 1 never acks
`ifdef WB_DEC_TIMEOUT_EN
    run_txn(16'h0110, 8'h00, 1'b0, 0, 0, -1);
    chk("lit timeout cnt", 32'(err_cnt), 32'h2);
    // ack on the very edge the watchdog would fire: ack wins
    run_txn(16'h0105, 8'h00, 1'b0, TMO + 1, 0, 8'h3C);
    chk("lit ack-vs-timeout m_dat", 32'(bus.m_dat_o), 32'h3C);
`else
    run_txn(16'h0110, 8'h00, 1'b0, 0, 120, -1);
    chk("lit no-timeout cnt", 32'(err_cnt), 32'h1);
`endif

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      int ak, dp;
      a  = {8'($urandom_range(0, 6)), 8'($urandom)};
`ifdef WB_DEC_TIMEOUT_EN
      ak = int'($urandom_range(0, 11));
`else
      ak = int'($urandom_range(0, 6));
`endif
      dp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      if (dp == ak) dp = 0;
`ifndef WB_DEC_TIMEOUT_EN
      if (ak == 0 && dp == 0) dp = int'($urandom_range(1, 12));
`endif
      run_txn(a, 8'($urandom), 1'($urandom), ak, dp, -1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      run_txn({8'($urandom_range(4, 255)), 8'($urandom)}, 8'h00, 1'b0, 0, 0, -1);
    end
    chk("lit saturated cnt", 32'(err_cnt), 32'hFF);

    // Master abort two cycles into ACTIVE: no ack, no error
    run_txn(16'h0300, 8'h11, 1'b1, 0, 2, -1);
    idle_cycle();

    // Reset in the middle of a second transaction
    chk_on = 1'b0;
    bus.m_adr_i = 16'h0102; bus.m_dat_i = 8'h99; bus.m_we_i = 1'b1;
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
    drive_slaves(1, 1'b0, -1);
    @(posedge clk); #1;
    drive_slaves(1, 1'b0, -1);
    @(posedge clk); #1;
    chk("lit mid s_stb", 32'(bus.s_stb_o), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("lit rst s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("lit rst s_stb", 32'(bus.s_stb_o), 32'h0);
    chk("lit rst m_ack", 32'(bus.m_ack_o), 32'h0);
    chk("lit rst m_err", 32'(bus.m_err_o), 32'h0);
    chk("lit rst m_dat", 32'(bus.m_dat_o), 32'h0);
    chk("lit rst cnt",   32'(err_cnt),     32'h0);
    chk("lit rst s_adr", 32'(bus.s_adr_o), 32'h0);
    chk("lit rst s_dat", 32'(bus.s_dat_o), 32'h0);
    chk("lit rst s_we",  32'(bus.s_we_o),  32'h0);
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    exp_cyc = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_cnt = '0;
    exp_adr = '0; exp_sdat = '0; exp_we = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;
    idle_cycle();

    // Normal operation after reset
    run_txn(16'h0001, 8'h77, 1'b0, 1, 0, 8'h42);
    chk("lit post-rst m_dat", 32'(bus.m_dat_o), 32'h42);
    repeat (3) idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
